// File: rtl/multicycle_add_sub_pkg.sv
// Shared definitions for the multi-cycle adder/subtractor: FSM encodings,
// default widths and the result-flag bundle.
package multicycle_add_sub_pkg;

  localparam int DEF_DATA_W  = 32;
  localparam int DEF_CHUNK_W = 8;

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_RUN  = 2'b01;
  localparam logic [1:0] ST_DONE = 2'b10;

  typedef struct packed {
    logic co;
    logic ovf;
    logic zero;
  } flags_t;

  // One extra bit keeps the chunk counter non-zero width when NUM_CHUNKS == 1.
  function automatic int cnt_width(input int num_chunks);
    return $clog2(num_chunks) + 1;
  endfunction

endpackage

// File: rtl/multicycle_add_sub_rc_add_slice.sv
// W-bit ripple-carry slice built from a chain of 1-bit full-adder cells.
// Also exposes the carry into the top bit for signed-overflow detection.
module fa_cell (
  input  logic i_a,
  input  logic i_b,
  input  logic i_ci,
  output logic o_s,
  output logic o_co
);

  assign o_s  = i_a ^ i_b ^ i_ci;
  assign o_co = (i_a & i_b) | (i_ci & (i_a ^ i_b));

endmodule

module rc_add_slice #(
  parameter int W = 8
) (
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  input  logic         i_ci,
  output logic [W-1:0] o_s,
  output logic         o_co,
  output logic         o_c_msb
);

  logic [W:0] w_c;

  assign w_c[0] = i_ci;

  for (genvar gi = 0; gi < W; gi++) begin : g_fa
    fa_cell u_fa (
      .i_a  (i_a[gi]),
      .i_b  (i_b[gi]),
      .i_ci (w_c[gi]),
      .o_s  (o_s[gi]),
      .o_co (w_c[gi+1])
    );
  end

  assign o_co    = w_c[W];
  assign o_c_msb = w_c[W-1];

endmodule

// File: rtl/multicycle_add_sub.sv
// Multi-cycle adder/subtractor resolving CHUNK_W bits per clock behind a
// start/done handshake; result and flags are only updated on completion.
//
// state   | meaning
// IDLE    | waiting for i_start
// RUN     | one chunk resolved per cycle, o_busy high
// DONE    | one-cycle o_done pulse; i_start accepted back-to-back
module multicycle_add_sub
  import multicycle_add_sub_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int CHUNK_W = DEF_CHUNK_W
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_start,
  input  logic              i_sub,
  input  logic [DATA_W-1:0] i_a,
  input  logic [DATA_W-1:0] i_b,
  output logic              o_busy,
  output logic              o_done,
  output logic [DATA_W-1:0] o_r,
  output logic              o_co,
  output logic              o_ovf,
  output logic              o_zero
);

  localparam int NUM_CHUNKS = DATA_W / CHUNK_W;
  localparam int CNT_W      = cnt_width(NUM_CHUNKS);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_CHUNKS - 1);

  logic [1:0]         r_state;
  logic [DATA_W-1:0]  r_a_sh;
  logic [DATA_W-1:0]  r_b_sh;
  logic               r_cy;
  logic [CNT_W-1:0]   r_cnt;
  logic [DATA_W-1:0]  r_acc;
  logic [DATA_W-1:0]  r_r;
  flags_t             r_flags;

  logic [CHUNK_W-1:0] w_sum;
  logic               w_slice_co;
  logic               w_slice_cmsb;
  logic [DATA_W-1:0]  w_acc_nxt;
  logic               w_last;

  rc_add_slice #(.W(CHUNK_W)) u_slice (
    .i_a     (r_a_sh[CHUNK_W-1:0]),
    .i_b     (r_b_sh[CHUNK_W-1:0]),
    .i_ci    (r_cy),
    .o_s     (w_sum),
    .o_co    (w_slice_co),
    .o_c_msb (w_slice_cmsb)
  );

  // New chunk enters at the MSB end; after NUM_CHUNKS shifts the LSB chunk lands at bit 0.
  assign w_acc_nxt = DATA_W'({w_sum, r_acc} >> CHUNK_W);
  assign w_last    = (r_cnt == LAST_CNT);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
      r_a_sh  <= '0;
      r_b_sh  <= '0;
      r_cy    <= 1'b0;
      r_cnt   <= '0;
      r_acc   <= '0;
      r_r     <= '0;
      r_flags <= '{co: 1'b0, ovf: 1'b0, zero: 1'b1};
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (i_start) begin
            r_a_sh  <= i_a;
            r_b_sh  <= i_b ^ {DATA_W{i_sub}};
            r_cy    <= i_sub;
            r_cnt   <= '0;
            r_state <= ST_RUN;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_RUN: begin
          r_a_sh <= r_a_sh >> CHUNK_W;
          r_b_sh <= r_b_sh >> CHUNK_W;
          r_acc  <= w_acc_nxt;
          r_cy   <= w_slice_co;
          r_cnt  <= r_cnt + 1'b1;
          if (w_last) begin
            r_r          <= w_acc_nxt;
            r_flags.co   <= w_slice_co;
            r_flags.ovf  <= w_slice_cmsb ^ w_slice_co;
            r_flags.zero <= (w_acc_nxt == '0);
            r_state      <= ST_DONE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_busy = (r_state == ST_RUN);
  assign o_done = (r_state == ST_DONE);
  assign o_r    = r_r;
  assign o_co   = r_flags.co;
  assign o_ovf  = r_flags.ovf;
  assign o_zero = r_flags.zero;

endmodule
